// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encoding, TAP next-state function,
// and instruction register sizing/opcodes used by the IR and decoder.
package jtag_pkg;

  // IEEE 1149.1 TAP state codes; all 16 values of the 4-bit field are legal
  localparam logic [3:0] TAP_TLR     = 4'hF;
  localparam logic [3:0] TAP_RTI     = 4'hC;
  localparam logic [3:0] TAP_SELDR   = 4'h7;
  localparam logic [3:0] TAP_CAPDR   = 4'h6;
  localparam logic [3:0] TAP_SHDR    = 4'h2;
  localparam logic [3:0] TAP_EX1DR   = 4'h1;
  localparam logic [3:0] TAP_PAUSEDR = 4'h3;
  localparam logic [3:0] TAP_EX2DR   = 4'h0;
  localparam logic [3:0] TAP_UPDDR   = 4'h5;
  localparam logic [3:0] TAP_SELIR   = 4'h4;
  localparam logic [3:0] TAP_CAPIR   = 4'hE;
  localparam logic [3:0] TAP_SHIR    = 4'hA;
  localparam logic [3:0] TAP_EX1IR   = 4'h9;
  localparam logic [3:0] TAP_PAUSEIR = 4'hB;
  localparam logic [3:0] TAP_EX2IR   = 4'h8;
  localparam logic [3:0] TAP_UPDIR   = 4'hD;

  // Instruction register width and the mandatory opcodes
  localparam int unsigned IR_DATA_WIDTH = 4;
  localparam logic [IR_DATA_WIDTH-1:0] IR_IDCODE = 4'b0001;
  localparam logic [IR_DATA_WIDTH-1:0] IR_BYPASS = 4'b1111;

  typedef enum logic [3:0] {
    ST_TLR     = TAP_TLR,
    ST_RTI     = TAP_RTI,
    ST_SELDR   = TAP_SELDR,
    ST_CAPDR   = TAP_CAPDR,
    ST_SHDR    = TAP_SHDR,
    ST_EX1DR   = TAP_EX1DR,
    ST_PAUSEDR = TAP_PAUSEDR,
    ST_EX2DR   = TAP_EX2DR,
    ST_UPDDR   = TAP_UPDDR,
    ST_SELIR   = TAP_SELIR,
    ST_CAPIR   = TAP_CAPIR,
    ST_SHIR    = TAP_SHIR,
    ST_EX1IR   = TAP_EX1IR,
    ST_PAUSEIR = TAP_PAUSEIR,
    ST_EX2IR   = TAP_EX2IR,
    ST_UPDIR   = TAP_UPDIR
  } tap_state_e;

  // TAP transition rule: the state entered on the next TCK given the TMS sample
  function automatic tap_state_e tap_next(input tap_state_e state, input logic tms);
    tap_next = ST_TLR;
    case (state)
      ST_TLR:     tap_next = tms ? ST_TLR     : ST_RTI;
      ST_RTI:     tap_next = tms ? ST_SELDR   : ST_RTI;
      ST_SELDR:   tap_next = tms ? ST_SELIR   : ST_CAPDR;
      ST_CAPDR:   tap_next = tms ? ST_EX1DR   : ST_SHDR;
      ST_SHDR:    tap_next = tms ? ST_EX1DR   : ST_SHDR;
      ST_EX1DR:   tap_next = tms ? ST_UPDDR   : ST_PAUSEDR;
      ST_PAUSEDR: tap_next = tms ? ST_EX2DR   : ST_PAUSEDR;
      ST_EX2DR:   tap_next = tms ? ST_UPDDR   : ST_SHDR;
      ST_UPDDR:   tap_next = tms ? ST_SELDR   : ST_RTI;
      ST_SELIR:   tap_next = tms ? ST_TLR     : ST_CAPIR;
      ST_CAPIR:   tap_next = tms ? ST_EX1IR   : ST_SHIR;
      ST_SHIR:    tap_next = tms ? ST_EX1IR   : ST_SHIR;
      ST_EX1IR:   tap_next = tms ? ST_UPDIR   : ST_PAUSEIR;
      ST_PAUSEIR: tap_next = tms ? ST_EX2IR   : ST_PAUSEIR;
      ST_EX2IR:   tap_next = tms ? ST_UPDIR   : ST_SHIR;
      ST_UPDIR:   tap_next = tms ? ST_SELDR   : ST_RTI;
      default:    tap_next = ST_TLR;
    endcase
  endfunction

endpackage

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state FSM clocked by TCK, steered by TMS,
// with per-state strobes for the IR/DR chains, TDO mux select and TDO enable.
// Every output is decoded from the state register only.
module tap_controller
  import jtag_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  output logic [3:0] STATE,
  output logic       TLR,
  output logic       RTI,
  output logic       CAPTURE_IR,
  output logic       SHIFT_IR,
  output logic       UPDATE_IR,
  output logic       CAPTURE_DR,
  output logic       SHIFT_DR,
  output logic       UPDATE_DR,
  output logic       SELECT_IR,
  output logic       TDO_EN
);

  tap_state_e state_q;
  tap_state_e state_d;

  // State register; TRST wins over TMS and aborts any scan straight to TLR
  always_ff @(posedge TCK) begin
    if (TRST) begin
      state_q <= ST_TLR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state from TMS, and output decode from the current state only
  always_comb begin
    state_d    = tap_next(state_q, TMS);
    STATE      = state_q;
    TLR        = 1'b0;
    RTI        = 1'b0;
    CAPTURE_IR = 1'b0;
    SHIFT_IR   = 1'b0;
    UPDATE_IR  = 1'b0;
    CAPTURE_DR = 1'b0;
    SHIFT_DR   = 1'b0;
    UPDATE_DR  = 1'b0;
    SELECT_IR  = 1'b0;
    TDO_EN     = 1'b0;
    case (state_q)
      ST_TLR:   TLR = 1'b1;
      ST_RTI:   RTI = 1'b1;
      ST_CAPDR: CAPTURE_DR = 1'b1;
      ST_SHDR: begin
        SHIFT_DR = 1'b1;
        TDO_EN   = 1'b1;
      end
      ST_UPDDR: UPDATE_DR = 1'b1;
      ST_CAPIR: CAPTURE_IR = 1'b1;
      ST_SHIR: begin
        SHIFT_IR = 1'b1;
        TDO_EN   = 1'b1;
      end
      ST_UPDIR: UPDATE_IR = 1'b1;
      default: ;
    endcase
    case (state_q)
      ST_SELIR, ST_CAPIR, ST_SHIR, ST_EX1IR,
      ST_PAUSEIR, ST_EX2IR, ST_UPDIR: SELECT_IR = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tap_controller.sv
// Testbench for tap_controller: directed scans with literal expected state
// walks, then random TMS/TRST against a transition-table reference model.
module tb_tap_controller;

  logic       TCK = 1'b0;
  logic       TRST;
  logic       TMS;
  logic [3:0] STATE;
  logic       TLR, RTI, CAPTURE_IR, SHIFT_IR, UPDATE_IR;
  logic       CAPTURE_DR, SHIFT_DR, UPDATE_DR, SELECT_IR, TDO_EN;

  int asserts  = 0;
  int failures = 0;

  logic [3:0] model_state = 4'hF;
  logic [3:0] next0 [16];
  logic [3:0] next1 [16];
  bit         visited [16];

  int cnt_cap_ir, cnt_sh_ir, cnt_upd_ir, cnt_sel_ir, cnt_tdo_en;
  int cnt_cap_dr, cnt_sh_dr, cnt_upd_dr;

  tap_controller dut (
    .TCK        (TCK),
    .TRST       (TRST),
    .TMS        (TMS),
    .STATE      (STATE),
    .TLR        (TLR),
    .RTI        (RTI),
    .CAPTURE_IR (CAPTURE_IR),
    .SHIFT_IR   (SHIFT_IR),
    .UPDATE_IR  (UPDATE_IR),
    .CAPTURE_DR (CAPTURE_DR),
    .SHIFT_DR   (SHIFT_DR),
    .UPDATE_DR  (UPDATE_DR),
    .SELECT_IR  (SELECT_IR),
    .TDO_EN     (TDO_EN)
  );

  // Free-running test clock
  always #5 TCK = ~TCK;

  task automatic checkBit(input string tag, input logic obs, input logic expv);
    asserts++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int expv);
    asserts++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic checkState(input string tag, input logic [3:0] expv);
    asserts++;
    assert (STATE === expv) else begin
      failures++;
      $error("[TB] FAIL %s: observed STATE %h expected %h", tag, STATE, expv);
    end
  endtask

  // Compare every output against what the model state says it should be
  task automatic checkOutput(input string tag);
    logic [3:0] s;
    s = model_state;
    checkState({tag, ":STATE"}, s);
    checkBit({tag, ":TLR"},        TLR,        s == 4'hF);
    checkBit({tag, ":RTI"},        RTI,        s == 4'hC);
    checkBit({tag, ":CAPTURE_IR"}, CAPTURE_IR, s == 4'hE);
    checkBit({tag, ":SHIFT_IR"},   SHIFT_IR,   s == 4'hA);
    checkBit({tag, ":UPDATE_IR"},  UPDATE_IR,  s == 4'hD);
    checkBit({tag, ":CAPTURE_DR"}, CAPTURE_DR, s == 4'h6);
    checkBit({tag, ":SHIFT_DR"},   SHIFT_DR,   s == 4'h2);
    checkBit({tag, ":UPDATE_DR"},  UPDATE_DR,  s == 4'h5);
    checkBit({tag, ":SELECT_IR"},  SELECT_IR,  s inside {4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD});
    checkBit({tag, ":TDO_EN"},     TDO_EN,     s == 4'hA || s == 4'h2);
  endtask

  task automatic clearCounts();
    cnt_cap_ir = 0; cnt_sh_ir = 0; cnt_upd_ir = 0; cnt_sel_ir = 0; cnt_tdo_en = 0;
    cnt_cap_dr = 0; cnt_sh_dr = 0; cnt_upd_dr = 0;
  endtask

  // One TCK: drive inputs, advance model at the posedge, check at the negedge
  task automatic applyStimulus(input logic tms, input logic trst, input string tag);
    TMS  = tms;
    TRST = trst;
    @(posedge TCK);
    if (trst) model_state = 4'hF;
    else      model_state = tms ? next1[model_state] : next0[model_state];
    @(negedge TCK);
    checkOutput(tag);
    visited[STATE] = 1'b1;
    cnt_cap_ir += int'(CAPTURE_IR);
    cnt_sh_ir  += int'(SHIFT_IR);
    cnt_upd_ir += int'(UPDATE_IR);
    cnt_sel_ir += int'(SELECT_IR);
    cnt_tdo_en += int'(TDO_EN);
    cnt_cap_dr += int'(CAPTURE_DR);
    cnt_sh_dr  += int'(SHIFT_DR);
    cnt_upd_dr += int'(UPDATE_DR);
  endtask

  // Directed TMS sequence (first bit = MSB) with a literal expected state walk
  task automatic runSeq(input string tag, input logic [15:0] tms_bits,
                        input logic [63:0] states, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(tms_bits[n-1-i], 1'b0, tag);
      checkState({tag, ":walk"}, states[4*(n-1-i) +: 4]);
    end
  endtask

  initial begin
    // Reference transition table, written straight from the TAP diagram
    next0[4'hF] = 4'hC; next1[4'hF] = 4'hF;
    next0[4'hC] = 4'hC; next1[4'hC] = 4'h7;
    next0[4'h7] = 4'h6; next1[4'h7] = 4'h4;
    next0[4'h6] = 4'h2; next1[4'h6] = 4'h1;
    next0[4'h2] = 4'h2; next1[4'h2] = 4'h1;
    next0[4'h1] = 4'h3; next1[4'h1] = 4'h5;
    next0[4'h3] = 4'h3; next1[4'h3] = 4'h0;
    next0[4'h0] = 4'h2; next1[4'h0] = 4'h5;
    next0[4'h5] = 4'hC; next1[4'h5] = 4'h7;
    next0[4'h4] = 4'hE; next1[4'h4] = 4'hF;
    next0[4'hE] = 4'hA; next1[4'hE] = 4'h9;
    next0[4'hA] = 4'hA; next1[4'hA] = 4'h9;
    next0[4'h9] = 4'hB; next1[4'h9] = 4'hD;
    next0[4'hB] = 4'hB; next1[4'hB] = 4'h8;
    next0[4'h8] = 4'hA; next1[4'h8] = 4'hD;
    next0[4'hD] = 4'hC; next1[4'hD] = 4'h7;
    for (int i = 0; i < 16; i++) visited[i] = 1'b0;
    clearCounts();
    TRST = 1'b1;
    TMS  = 1'b0;

    $display("[TB] reset");
    applyStimulus(1'b0, 1'b1, "reset0");
    applyStimulus(1'b0, 1'b1, "reset1");
    checkState("reset_state", 4'hF);

    $display("[TB] IR scan");
    clearCounts();
    runSeq("ir_scan", 16'b01100000110, 64'hC74EAAAA9DC, 11);
    checkInt("ir_capture_cycles", cnt_cap_ir, 1);
    checkInt("ir_shift_cycles",   cnt_sh_ir,  4);
    checkInt("ir_tdo_en_cycles",  cnt_tdo_en, 4);
    checkInt("ir_update_cycles",  cnt_upd_ir, 1);
    checkInt("ir_select_cycles",  cnt_sel_ir, 8);

    $display("[TB] DR scan with pause");
    clearCounts();
    runSeq("dr_scan", 16'b10010010110, 64'h7621330215C, 11);
    checkInt("dr_capture_cycles", cnt_cap_dr, 1);
    checkInt("dr_shift_cycles",   cnt_sh_dr,  2);
    checkInt("dr_update_cycles",  cnt_upd_dr, 1);
    checkInt("dr_select_ir",      cnt_sel_ir, 0);

    $display("[TB] TMS=1 x5 from Shift-IR");
    runSeq("to_shir", 16'b1100, 64'h74EA, 4);
    clearCounts();
    runSeq("tms_ones", 16'b11111, 64'h9D74F, 5);
    checkBit("tms_ones_tlr", TLR, 1'b1);
    checkInt("tms_ones_update_ir", cnt_upd_ir, 1);

    $display("[TB] reset during Shift-DR");
    runSeq("to_shdr", 16'b0100, 64'hC762, 4);
    clearCounts();
    applyStimulus(1'b0, 1'b1, "trst_mid");
    checkState("trst_mid_state", 4'hF);
    applyStimulus(1'b0, 1'b0, "post_trst");
    checkInt("trst_mid_update_dr", cnt_upd_dr, 0);

    $display("[TB] random TMS");
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 255) == 0), "rand");
    end
    for (int i = 0; i < 16; i++) begin
      checkBit($sformatf("visited_%h", i[3:0]), visited[i], 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/tap_controller.md
# tap_controller

IEEE 1149.1 TAP state machine for the JTAG block. Advances the 16-state TAP FSM on each rising TCK edge from TMS. Produces the one-hot-per-state strobes consumed by the downstream registers: the instruction register uses TLR, CAPTURE_IR, SHIFT_IR and UPDATE_IR; the DR chain uses the DR strobes. It also drives the TDO mux select and the TDO output enable.

## Interface
- No parameters; state width is fixed at 4 bits by the 1149.1 encoding.
- TCK  in  1  sole clock; all flops on posedge TCK.
- TRST  in  1  reset, synchronous, active-high; sampled on posedge TCK.
- TMS  in  1  test mode select; sampled on posedge TCK.
- STATE  out  4  current TAP state, encoded as below.
- TLR  out  1  high while in Test-Logic-Reset.
- RTI  out  1  high while in Run-Test/Idle.
- CAPTURE_IR, SHIFT_IR, UPDATE_IR  out  1 each  high while in the matching IR state.
- CAPTURE_DR, SHIFT_DR, UPDATE_DR  out  1 each  high while in the matching DR state.
- SELECT_IR  out  1  high in every IR-column state (Select-IR-Scan through Update-IR); TDO mux select.
- TDO_EN  out  1  high in Shift-IR or Shift-DR.

## Operation
- State encoding (hex):
  - TLR=F, RTI=C
  - SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5
  - SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D
- Transitions, written as state: TMS=0 target / TMS=1 target:
  - TLR: RTI / TLR
  - RTI: RTI / SelDR
  - SelDR: CapDR / SelIR
  - CapDR: ShDR / Ex1DR
  - ShDR: ShDR / Ex1DR
  - Ex1DR: PauseDR / UpdDR
  - PauseDR: PauseDR / Ex2DR
  - Ex2DR: ShDR / UpdDR
  - UpdDR: RTI / SelDR
  - SelIR: CapIR / TLR
  - IR column (CapIR through UpdIR) mirrors the DR column, with UpdIR: RTI / SelDR.
- All outputs are pure functions of the state register. No output depends combinationally on TMS.
- From any state, five consecutive TMS=1 samples reach TLR.
- TRST=1 at a posedge forces TLR regardless of TMS. TRST has priority over TMS.
- Reset mid-scan (for example in ShIR) aborts the scan: next state is TLR and no Update strobe is issued.
- The 4-bit state register reaches no illegal states; all 16 codes are legal.

## Timing
- Reset values (the cycle after TRST is sampled high): STATE=4'hF, TLR=1, all other outputs 0.
- Latency is one TCK from the TMS sample to the new STATE. Outputs change in the same cycle as STATE, driven from flops or decoded from the state flop only.
- Each strobe is high for exactly the TCK cycles spent in its state:
  - CAPTURE_* and UPDATE_* last one cycle per visit.
  - SHIFT_* lasts N cycles for N TMS=0 samples taken while in Shift.
- Downstream contract: the IR and DR registers capture or shift on the posedge that ends the strobe's cycle; update latches act on the negedge within the UPDATE_* cycle.
- Power-up without TRST is unspecified. The bench always asserts TRST first.

## Structure
- Shared package jtag_pkg holds:
  - the 16 state-encoding localparams (TAP_TLR … TAP_UPDIR);
  - a next-state function tap_next(state, tms);
  - IR_DATA_WIDTH and the IDCODE/BYPASS opcodes, for use by the IR and decoder.
- Single module, no sub-module: state register, next-state logic via tap_next, output decode.

## Test plan
- Reset: TRST=1 for 2 TCK with TMS=0 → STATE=F, TLR=1, all strobes 0. Release TRST with TMS=0 → STATE=C, RTI=1 next cycle.
- IR scan from TLR, TMS sequence 0,1,1,0,0,0,0,0,1,1,0:
  - STATE walks C,7,4,E,A,A,A,A,9,D,C;
  - CAPTURE_IR high 1 cycle, SHIFT_IR and TDO_EN high 4 cycles, UPDATE_IR high 1 cycle;
  - SELECT_IR high from state 4 through D.
- DR scan with pause, from RTI, TMS 1,0,0,1,0,0,1,0,1,1,0 → STATE 7,6,2,1,3,3,0,2,1,5,C. SHIFT_DR high for the two Shift-DR visits; UPDATE_DR high exactly once.
- Reach TLR by TMS: from ShIR apply TMS=1 ×5 → STATE 9,D,7,4,F; TLR=1 on the fifth cycle; no UPDATE_IR strobe is lost (exactly one, in state D).
- Reset mid-operation: in ShDR, assert TRST for one posedge with TMS=0 → next STATE=F. UPDATE_DR never asserts.
- Exhaustive: random TMS for 10k cycles, checked against a reference model of the transition list. Every state is visited, and every output matches its state decode each cycle.
